xbus_arbiter: RTL and testbench
===============================

# xbus_arbiter

Two-master round-robin arbiter for the darkbridge X bus. It sits between the CPU bridge (master 0) and a second bus master such as a DMA engine or debug port (master 1), and drives the single X-bus port that feeds the CS address decode (bram, io, sdram, unmapped). A per-transfer watchdog completes any transfer the selected slave never acknowledges. The watchdog records a sticky bus error and returns 32'hdeadbeef to the master.

## Interface
- TIMEOUT, 255: grant cycles without slave ack before forced completion; must be ≥1; counter width clog2(TIMEOUT+1).
- CLK  in  1  system clock, all state on rising edge.
- RESN  in  1  asynchronous, active-low reset.
- M0_XDREQ, M1_XDREQ  in  1  master request; held high with address and controls stable until that master's XDACK.
- M0_XADDR, M1_XADDR  in  32  address.
- M0_XATAO, M1_XATAO  in  32  write data.
- M0_XRD/M0_XWR, M1_XRD/M1_XWR  in  1  read/write strobes.
- M0_XBE, M1_XBE  in  4  byte enables.
- M0_XATAI, M1_XATAI  out  32  read data to master.
- M0_XDACK, M1_XDACK  out  1  one-cycle completion pulse.
- S_XDREQ  out  1  request to decoder.
- S_XADDR, S_XATAO  out  32  muxed address and write data.
- S_XRD, S_XWR  out  1  muxed strobes.
- S_XBE  out  4  muxed byte enables.
- S_XATAI  in  32  read data from decoder.
- S_XDACK  in  1  slave completion pulse.
- GNT  out  2  one-hot current owner; 00 when idle.
- BUSERR  out  1  sticky timeout flag.
- BUSERR_ADDR  out  32  address of the most recent timed-out transfer.
- ERR_CLR  in  1  synchronous clear of BUSERR.

## Operation
- States:
  - IDLE
  - GRANT0
  - GRANT1
- Reset, asynchronous on RESN low: state IDLE, LAST=1, counter 0, BUSERR=0, BUSERR_ADDR=0.
  - All outputs are 0 during and after reset, because GNT=00.
- IDLE transitions:
  - Only M0_XDREQ high → GRANT0.
  - Only M1_XDREQ high → GRANT1.
  - Both high → grant the master ≠ LAST, so M0 wins the first tie after reset.
  - Neither high → stay in IDLE.
  - Entering a grant state clears the counter.
- GRANTn:
  - S_* signals combinationally equal master n's signals.
  - S_XDREQ = Mn_XDREQ.
  - Mn_XATAI = S_XATAI.
  - Mn_XDACK = S_XDACK.
  - The non-owner's XDACK is 0 and its XATAI is 0.
- Normal end: S_XDACK high in GRANTn → LAST←n, go to IDLE.
- Timeout end: when the counter equals TIMEOUT-1 and S_XDACK is low in that cycle, then in the same cycle:
  - Mn_XDACK is forced to 1 and Mn_XATAI to 32'hdeadbeef.
  - Next state: BUSERR←1, BUSERR_ADDR←Mn_XADDR, LAST←n, go to IDLE.
- Timeout cycle with simultaneous S_XDACK: the real ack and real data win, and no error is recorded.
- Counter: increments each GRANTn cycle without ack; saturates and never wraps.
- Early withdrawal: if the owner drops XDREQ while in GRANTn, S_XDREQ falls the same cycle and the state goes to IDLE next cycle. No ack is issued, no error is recorded, and LAST is unchanged.
- An S_XDACK arriving while in IDLE (stray or late slave ack) is ignored.
- Writes are passed through unchanged; the arbiter stores no data.
- BUSERR priority: when ERR_CLR and a timeout occur in the same cycle, set wins (BUSERR=1). ERR_CLR does not alter BUSERR_ADDR.

## Timing
- Request seen in IDLE at cycle t → GNT and S_XDREQ valid from cycle t+1.
- A zero-wait slave acks in t+1, so the master sees XDACK in t+1.
- One IDLE cycle separates every transfer: minimum 2 cycles per transfer, maximum throughput 1 transfer per 2 cycles.
- Worst-case wait for a requester with the other master active: one full transfer of the other master plus 1 cycle. No starvation.
- Timeout ack lands in grant cycle TIMEOUT (1-based).
  - TIMEOUT=1 means an ack is forced in the first grant cycle unless S_XDACK is high.
- Data path is purely combinational through the arbiter; added latency is only the IDLE→GRANT cycle.
- RESN low mid-grant: GNT, S_XDREQ and all XDACK outputs drop asynchronously; no ack is delivered.

## Test plan
- M0 read 0x0000_0010, zero-wait slave returning 0x1234_5678:
  - GNT=01 and S_XDREQ high one cycle after the request.
  - M0_XDACK pulses that cycle with 0x1234_5678; M1_XDACK stays 0.
- M0 and M1 request simultaneously, each holding 3 transfers, slave with 2 wait states:
  - Grants alternate M0, M1, M0, M1, M0, M1.
  - One IDLE cycle between grants; each XDACK is a single-cycle pulse.
- TIMEOUT=4, M1 write to 0xC000_0000, slave never acks:
  - M1_XDACK in the 4th grant cycle with data 0xdeadbeef.
  - BUSERR=1 and BUSERR_ADDR=0xC000_0000 on the next edge.
  - Pulsing ERR_CLR then clears BUSERR.
- TIMEOUT=4, slave acks exactly in the 4th grant cycle with 0xAAAA_5555:
  - Master receives 0xAAAA_5555 and BUSERR stays 0.
  - Separately, timeout concurrent with ERR_CLR → BUSERR=1.
- RESN pulled low during GRANT0 with the slave pending:
  - All outputs 0 immediately.
  - After release, M0 still requesting → GRANT0 one cycle later.
  - A stray S_XDACK while in IDLE produces no master ack.
- M0 drops XDREQ in its 2nd grant cycle before any ack:
  - S_XDREQ falls the same cycle; IDLE next cycle.
  - No ack, BUSERR=0; a pending M1 request is granted after that IDLE cycle.

Source files
------------

// File: rtl/xbus_arbiter_if.sv
// One X-bus master/slave link: request, address, strobes, write data out;
// read data and completion pulse back.
interface xbus_arbiter_if;
  logic        XDREQ;
  logic [31:0] XADDR;
  logic [31:0] XATAO;
  logic        XRD;
  logic        XWR;
  logic [3:0]  XBE;
  logic [31:0] XATAI;
  logic        XDACK;

  // Handshake: the master holds XDREQ with address/controls stable until the
  // single-cycle XDACK pulse; the slave may ack in any cycle XDREQ is high.
  modport master (output XDREQ, XADDR, XATAO, XRD, XWR, XBE,
                  input  XATAI, XDACK);
  modport slave  (input  XDREQ, XADDR, XATAO, XRD, XWR, XBE,
                  output XATAI, XDACK);
endinterface

// File: rtl/xbus_arbiter.sv
// Two-master round-robin X-bus arbiter with a per-transfer ack watchdog that
// completes hung transfers with 32'hdeadbeef and latches a sticky bus error.
module xbus_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RESN,
  xbus_arbiter_if.slave  m0,
  xbus_arbiter_if.slave  m1,
  xbus_arbiter_if.master s,
  output logic [1:0]    GNT,
  output logic          BUSERR,
  output logic [31:0]   BUSERR_ADDR,
  input  logic          ERR_CLR,
  output logic [1:0]    state_dbg
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [31:0]   ERR_DATA = 32'hdeadbeef;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0]    state;
  logic          last;
  logic [CW-1:0] cnt;
  logic          g0;
  logic          g1;
  logic          granted;
  logic          own_req;
  logic          timeout;
  logic          ack;
  logic [31:0]   rdata;

  assign g0      = (state == GRANT0);
  assign g1      = (state == GRANT1);
  assign granted = g0 | g1;
  assign own_req = (g0 & m0.XDREQ) | (g1 & m1.XDREQ);

  // Owner mux; everything toward the decoder is zero while idle.
  always_comb begin
    s.XADDR = '0;
    s.XATAO = '0;
    s.XRD   = 1'b0;
    s.XWR   = 1'b0;
    s.XBE   = '0;
    if (g0) begin
      s.XADDR = m0.XADDR;
      s.XATAO = m0.XATAO;
      s.XRD   = m0.XRD;
      s.XWR   = m0.XWR;
      s.XBE   = m0.XBE;
    end else if (g1) begin
      s.XADDR = m1.XADDR;
      s.XATAO = m1.XATAO;
      s.XRD   = m1.XRD;
      s.XWR   = m1.XWR;
      s.XBE   = m1.XBE;
    end
  end

  assign s.XDREQ = own_req;

  // A real ack in the last watchdog cycle beats the forced completion.
  assign timeout = own_req & ~s.XDACK & (cnt == CNT_LAST);
  assign ack     = granted & (s.XDACK | timeout);
  assign rdata   = timeout ? ERR_DATA : s.XATAI;

  assign m0.XDACK = g0 & ack;
  assign m1.XDACK = g1 & ack;
  assign m0.XATAI = g0 ? rdata : 32'h0;
  assign m1.XATAI = g1 ? rdata : 32'h0;

  assign GNT       = {g1, g0};
  assign state_dbg = state;

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          // On a tie the master that did not finish last goes first.
          if (m0.XDREQ && (!m1.XDREQ || last)) state <= GRANT0;
          else if (m1.XDREQ)                   state <= GRANT1;
        end
        GRANT0, GRANT1: begin
          if (s.XDACK || timeout) begin
            last  <= g1;
            state <= IDLE;
          end else if (!own_req) begin
            state <= IDLE;
          end else if (cnt != CNT_LAST) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESN) begin
    if (!RESN) begin
      BUSERR      <= 1'b0;
      BUSERR_ADDR <= 32'h0;
    end else if (timeout) begin
      BUSERR      <= 1'b1;
      BUSERR_ADDR <= s.XADDR;
    end else if (ERR_CLR) begin
      BUSERR <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xbus_arbiter.sv
// Directed bench for xbus_arbiter (TIMEOUT=4): cycle-by-cycle vector table
// plus hand sequences for reset mid-grant and round-robin alternation.
module tb_xbus_arbiter;

  localparam int TIMEOUT = 4;
  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'hC000_0000;
  localparam logic [31:0] W0 = 32'h0000_0000;
  localparam logic [31:0] W1 = 32'h5555_0000;
  localparam logic [31:0] DB = 32'hdeadbeef;

  logic        CLK = 1'b0;
  logic        RESN = 1'b0;
  logic        ERR_CLR = 1'b0;
  logic [1:0]  GNT;
  logic [1:0]  state_dbg;
  logic        BUSERR;
  logic [31:0] BUSERR_ADDR;

  xbus_arbiter_if m0_if ();
  xbus_arbiter_if m1_if ();
  xbus_arbiter_if s_if ();

  xbus_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK         (CLK),
    .RESN        (RESN),
    .m0          (m0_if),
    .m1          (m1_if),
    .s           (s_if),
    .GNT         (GNT),
    .BUSERR      (BUSERR),
    .BUSERR_ADDR (BUSERR_ADDR),
    .ERR_CLR     (ERR_CLR),
    .state_dbg   (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic reset_dut();
    RESN = 1'b0;
    m0_if.XDREQ = 1'b0;
    m1_if.XDREQ = 1'b0;
    s_if.XDACK  = 1'b0;
    s_if.XATAI  = 32'h0;
    ERR_CLR     = 1'b0;
    repeat (2) @(posedge CLK);
    #1 RESN = 1'b1;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        m0_req;
    logic        m1_req;
    logic        s_ack;
    logic [31:0] s_data;
    logic        clr;
    logic [1:0]  gnt;
    logic        sreq;
    logic        m0_ack;
    logic [31:0] m0_data;
    logic        m1_ack;
    logic [31:0] m1_data;
    logic        berr;
    logic [31:0] eaddr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic m0r, input logic m1r, input logic sack, input logic [31:0] sd,
                     input logic clr, input logic [1:0] g, input logic sr, input logic m0a,
                     input logic [31:0] m0d, input logic m1a, input logic [31:0] m1d,
                     input logic be, input logic [31:0] ea);
    vec_t v;
    v.m0_req = m0r; v.m1_req = m1r; v.s_ack = sack; v.s_data = sd; v.clr = clr;
    v.gnt = g; v.sreq = sr; v.m0_ack = m0a; v.m0_data = m0d; v.m1_ack = m1a;
    v.m1_data = m1d; v.berr = be; v.eaddr = ea;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] exp_addr(input logic [1:0] g);
    return (g == 2'b01) ? A0 : (g == 2'b10) ? A1 : 32'h0;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] g);
    return (g == 2'b01) ? W0 : (g == 2'b10) ? W1 : 32'h0;
  endfunction

  // ---------------- stimulus ----------------
  logic [1:0] exp_q[$];
  int m0_left, m1_left, gc;
  logic [1:0] prev_gnt;
  logic prev_ack;

  initial begin
    m0_if.XADDR = A0; m0_if.XATAO = W0; m0_if.XRD = 1'b1; m0_if.XWR = 1'b0; m0_if.XBE = 4'hF;
    m1_if.XADDR = A1; m1_if.XATAO = W1; m1_if.XRD = 1'b0; m1_if.XWR = 1'b1; m1_if.XBE = 4'h3;

    //  m0 m1 ack data          clr  gnt  sreq m0a m0d           m1a m1d           berr eaddr
    add(0, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0); // reset
    add(0, 0, 1, 32'h1111_1111, 0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0); // stray ack
    add(1, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(1, 0, 1, 32'h1234_5678, 0, 2'b01, 1, 1, 32'h1234_5678, 0, 32'h0,         0, 32'h0); // zero-wait
    add(0, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(1, 1, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0); // tie, m0 was last
    add(1, 1, 0, 32'h0,         0, 2'b10, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(1, 1, 1, 32'hA5A5_A5A5, 0, 2'b10, 1, 0, 32'h0,         1, 32'hA5A5_A5A5, 0, 32'h0);
    add(1, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(1, 1, 0, 32'h0,         0, 2'b01, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 2'b01, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0); // withdraw
    add(0, 1, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 2'b10, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 2'b10, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 2'b10, 1, 0, 32'h0,         0, 32'h0,         0, 32'h0);
    add(0, 1, 0, 32'h0,         0, 2'b10, 1, 0, 32'h0,         1, DB,            0, 32'h0); // timeout
    add(0, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         1, A1);
    add(0, 0, 0, 32'h0,         1, 2'b00, 0, 0, 32'h0,         0, 32'h0,         1, A1);
    add(0, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 0, 32'h0,         0, 2'b01, 1, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 0, 32'h0,         0, 2'b01, 1, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 0, 32'h0,         0, 2'b01, 1, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 1, 32'hAAAA_5555, 0, 2'b01, 1, 1, 32'hAAAA_5555, 0, 32'h0,         0, A1); // ack on last cycle
    add(0, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 0, 32'h0,         0, 2'b01, 1, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 0, 32'h0,         0, 2'b01, 1, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 0, 32'h0,         0, 2'b01, 1, 0, 32'h0,         0, 32'h0,         0, A1);
    add(1, 0, 0, 32'h0,         1, 2'b01, 1, 1, DB,            0, 32'h0,         0, A1); // timeout + clr
    add(0, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         1, A0);
    add(0, 0, 0, 32'h0,         1, 2'b00, 0, 0, 32'h0,         0, 32'h0,         1, A0);
    add(0, 0, 0, 32'h0,         0, 2'b00, 0, 0, 32'h0,         0, 32'h0,         0, A0);

    // ---------- table-driven vectors ----------
    reset_dut();
    for (int i = 0; i < tbl.size(); i++) begin
      m0_if.XDREQ = tbl[i].m0_req;
      m1_if.XDREQ = tbl[i].m1_req;
      s_if.XDACK  = tbl[i].s_ack;
      s_if.XATAI  = tbl[i].s_data;
      ERR_CLR     = tbl[i].clr;
      #1;
      chk($sformatf("v%0d gnt", i),      32'(GNT),          32'(tbl[i].gnt));
      chk($sformatf("v%0d s_xdreq", i),  32'(s_if.XDREQ),   32'(tbl[i].sreq));
      chk($sformatf("v%0d s_xaddr", i),  s_if.XADDR,        exp_addr(tbl[i].gnt));
      chk($sformatf("v%0d s_xatao", i),  s_if.XATAO,        exp_wdata(tbl[i].gnt));
      chk($sformatf("v%0d s_xwr", i),    32'(s_if.XWR),     32'(tbl[i].gnt == 2'b10));
      chk($sformatf("v%0d m0_xdack", i), 32'(m0_if.XDACK),  32'(tbl[i].m0_ack));
      chk($sformatf("v%0d m0_xatai", i), m0_if.XATAI,       tbl[i].m0_data);
      chk($sformatf("v%0d m1_xdack", i), 32'(m1_if.XDACK),  32'(tbl[i].m1_ack));
      chk($sformatf("v%0d m1_xatai", i), m1_if.XATAI,       tbl[i].m1_data);
      chk($sformatf("v%0d buserr", i),   32'(BUSERR),       32'(tbl[i].berr));
      chk($sformatf("v%0d buserr_addr", i), BUSERR_ADDR,    tbl[i].eaddr);
      step();
    end

    // ---------- reset asserted mid-grant ----------
    reset_dut();
    m0_if.XDREQ = 1'b1;
    #1 chk("rst idle gnt", 32'(GNT), 32'h0);
    step();
    #1 chk("rst grant gnt", 32'(GNT), 32'h1);
    RESN = 1'b0;
    s_if.XDACK = 1'b1;
    s_if.XATAI = 32'h7777_7777;
    #1;
    chk("rst async gnt", 32'(GNT), 32'h0);
    chk("rst async s_xdreq", 32'(s_if.XDREQ), 32'h0);
    chk("rst async m0_xdack", 32'(m0_if.XDACK), 32'h0);
    chk("rst async m0_xatai", m0_if.XATAI, 32'h0);
    chk("rst async s_xaddr", s_if.XADDR, 32'h0);
    s_if.XDACK = 1'b0;
    RESN = 1'b1;
    step();
    chk("rst release regrant", 32'(GNT), 32'h1);
    m0_if.XDREQ = 1'b0;
    step();

    // ---------- alternation, 3 transfers each, 2 wait states ----------
    reset_dut();
    exp_q = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
    m0_left = 3; m1_left = 3; gc = 0; prev_gnt = 2'b00; prev_ack = 1'b0;
    for (int cyc = 0; cyc < 80 && (m0_left > 0 || m1_left > 0); cyc++) begin
      m0_if.XDREQ = (m0_left > 0);
      m1_if.XDREQ = (m1_left > 0);
      s_if.XDACK  = 1'b0;
      #1;
      if (GNT != 2'b00) gc++;
      else gc = 0;
      if (prev_ack) chk("alt idle after ack", 32'(GNT), 32'h0);
      if (GNT != 2'b00 && prev_gnt == 2'b00) begin
        if (exp_q.size() == 0) chk("alt extra grant", 32'(GNT), 32'h0);
        else chk("alt grant order", 32'(GNT), 32'(exp_q.pop_front()));
      end
      s_if.XDACK = (gc == 3);
      s_if.XATAI = 32'(cyc) + 32'h100;
      #1;
      if (gc == 3) begin
        chk("alt m0 ack", 32'(m0_if.XDACK), 32'(GNT == 2'b01));
        chk("alt m1 ack", 32'(m1_if.XDACK), 32'(GNT == 2'b10));
        if (m0_if.XDACK) m0_left--;
        if (m1_if.XDACK) m1_left--;
      end else begin
        chk("alt no m0 ack", 32'(m0_if.XDACK), 32'h0);
        chk("alt no m1 ack", 32'(m1_if.XDACK), 32'h0);
      end
      prev_ack = s_if.XDACK;
      prev_gnt = GNT;
      step();
    end
    chk("alt transfers done", 32'(m0_left + m1_left), 32'h0);
    chk("alt grants consumed", 32'(exp_q.size()), 32'h0);
    chk("alt no error", 32'(BUSERR), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
